serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder built around a single one-bit full-adder cell.
//  Sequential wrapper for the combinational full-adder stage: feeds the cell
//  one operand bit pair per clock and loops its carry-out back to carry-in
//  through a register. Consumes parallel operands on a start pulse.
//  Returns a parallel sum, carry and signed overflow WIDTH+1 cycles later.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; legal range 2..32
// PORTS
//  clk       in   1      single clock; all state updates on rising edge
//  rst       in   1      asynchronous, active-high reset
//  start     in   1      request; sampled only in IDLE
//  a         in   WIDTH  operand A, captured on accepted start
//  b         in   WIDTH  operand B, captured on accepted start
//  c_in      in   1      initial carry, captured on accepted start
//  busy      out  1      high in SHIFT and DONE states
//  done      out  1      one-cycle pulse, result valid
//  sum       out  WIDTH  registered result, a+b+c_in mod 2^WIDTH
//  c_out     out  1      registered carry out of MSB
//  overflow  out  1      registered signed overflow = carry into MSB ^ c_out
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; busy=0, done=0, sum=0, c_out=0,
//   overflow=0; operand shift regs, carry reg, bit counter cleared.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE: start=1 at edge -> load A<=a, B<=b, carry<=c_in, cnt<=0,
//   acc<=0; go SHIFT. start=0 -> stay IDLE.
//  SHIFT, one bit per cycle, LSB first: cell inputs A[0], B[0], carry.
//   acc <= {s, acc[WIDTH-1:1]}; A,B shift right with zero fill;
//   carry <= cell c_out; cnt <= cnt+1.
//   On cnt==WIDTH-1, on that edge also: sum <= {s, acc[WIDTH-1:1]},
//   c_out <= cell c_out, overflow <= carry ^ cell c_out
//   (carry = carry into MSB); go DONE.
//  DONE: done=1 for exactly one cycle; go IDLE unconditionally.
//  Latency: start accepted at edge E0 -> done high in the cycle after edge
//   E0+WIDTH. Next start accepted at first IDLE edge. Minimum issue interval
//   WIDTH+2 cycles.
//  sum/c_out/overflow change only on the final SHIFT edge (or reset).
//   They hold the previous result through IDLE and SHIFT.
//  start while busy (SHIFT or DONE): ignored, no queueing. Operands may
//   change freely after acceptance.
//  Reset mid-operation: operation discarded, no done pulse, outputs zeroed.
//  cnt width = $clog2(WIDTH); no wrap beyond WIDTH-1.
//  Carry chain is exact: c_in=1 with a=b=all-ones gives sum=all-ones,
//   c_out=1.
// STRUCTURE
//  Shared package serial_arith_pkg: state enum {IDLE, SHIFT, DONE}.
//   Also localparam helper CNT_W(WIDTH).
//  One sub-module: fa_cell (a, b, c_in -> s, c_out). Implementation:
//   s = a^b^c_in; c_out = (a&b)|((a^b)&c_in).
//  Instantiate fa_cell once. FSM, datapath shift regs and output regs live
//   in serial_adder.
// TESTING (WIDTH=8)
//  a=0x0F,b=0x01,c_in=0 -> done 9 cycles after start edge;
//   sum=0x10, c_out=0, ovf=0.
//  a=0xFF,b=0x01,c_in=0 -> sum=0x00, c_out=1, ovf=0.
//   a=0x7F,b=0x01 -> sum=0x80, c_out=0, ovf=1.
//  a=0xFF,b=0xFF,c_in=1 -> sum=0xFF, c_out=1, ovf=0.
//   a=b=0,c_in=1 -> sum=0x01.
//  Start 0x10+0x20, pulse start again with 0xAA+0x55 at cycle 3 ->
//   second start ignored; one done; sum=0x30; busy high 9 cycles.
//  Assert rst at cycle 4 of 0x3C+0x0C -> busy=0, sum=0 at once; no done.
//   Next start 0x01+0x02 -> sum=0x03.
//  Random 1000 back-to-back ops vs reference model a+b+c_in.
//   Check sum/c_out/ovf only on done; check they are stable otherwise.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic blocks.
// Holds the sequencer state encoding and the bit-counter width rule.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter must index 0..width-1; a 1-bit floor keeps tiny widths legal.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full-adder cell; the only arithmetic in the serial adder.
// Purely combinational, the carry loop is closed by the caller.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ c_in;
  assign c_out    = (a & b) | (half_sum & c_in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, registered carry.
// Result, carry and signed overflow are presented WIDTH+1 cycles after start.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cell_s;
  logic             cell_c;

  fa_cell u_fa (
    .a     (op_a[0]),
    .b     (op_b[0]),
    .c_in  (carry),
    .s     (cell_s),
    .c_out (cell_c)
  );

  // NOTE: every register here uses non-blocking assignment so all of them
  // sample the pre-edge values of each other (carry vs. cell_c in particular).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= c_in;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          acc   <= {cell_s, acc[WIDTH-1:1]};
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= cell_c;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB on this edge.
            sum      <= {cell_s, acc[WIDTH-1:1]};
            c_out    <= cell_c;
            overflow <= carry ^ cell_c;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): stimulus pushes expected results,
// a negedge monitor pops them on done and checks output stability in between.
`timescale 1ns/1ps
module tb_serial_adder;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             v;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t hold;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mc);
    exp_t        e;
    logic [WIDTH:0] full;
    full  = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mc};
    e.sum = full[WIDTH-1:0];
    e.c   = full[WIDTH];
    e.v   = (ma[WIDTH-1] == mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
    return e;
  endfunction

  // Monitor: results are checked only on done; otherwise they must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sum", 32'(sum), 32'(e.sum));
          check("c_out", 32'(c_out), 32'(e.c));
          check("overflow", 32'(overflow), 32'(e.v));
          hold = e;
        end
      end else begin
        check("stable", {22'd0, sum, c_out, overflow}, {22'd0, hold.sum, hold.c, hold.v});
      end
    end
  end

  // Raises start until the DUT accepts it, then counts negedges until done.
  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_op,
                       input logic tc, input exp_t e, output int tries, output int lat);
    a     = ta;
    b     = tb_op;
    c_in  = tc;
    start = 1'b1;
    q.push_back(e);
    tries = 0;
    do begin
      @(posedge clk);
      #1;
      tries++;
    end while (!busy && tries < 20);
    start = 1'b0;
    check("accepted", 32'(busy), 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 40);
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    exp_t             e;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int tries;
    int lat;
    int busy_cnt;
    int done_cnt;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, '{8'h10, 1'b0, 1'b0}};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0}};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1}};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, '{8'hFF, 1'b1, 1'b0}};
    vecs[4] = '{8'h00, 8'h00, 1'b1, '{8'h01, 1'b0, 1'b0}};
    vecs[5] = '{8'h80, 8'h80, 1'b0, '{8'h00, 1'b1, 1'b1}};

    hold  = '{8'h00, 1'b0, 1'b0};
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_c_out", 32'(c_out), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Directed vectors, each with the WIDTH+1 latency check.
    foreach (vecs[i]) begin
      wait_idle();
      issue(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].e, tries, lat);
      check("latency", 32'(lat), 32'(WIDTH + 1));
    end

    // A second start during SHIFT must be ignored.
    wait_idle();
    a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
    q.push_back('{8'h30, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (i == 3) begin
        a = 8'hAA; b = 8'h55; start = 1'b1;
      end
      if (i == 4) start = 1'b0;
    end
    check("busy_cycles", 32'(busy_cnt), 32'(WIDTH + 1));
    check("done_count", 32'(done_cnt), 32'd1);

    // Reset in the middle of an operation discards it.
    a = 8'h3C; b = 8'h0C; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_c_out", 32'(c_out), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    hold = '{8'h00, 1'b0, 1'b0};
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(8'h01, 8'h02, 1'b0, '{8'h03, 1'b0, 1'b0}, tries, lat);
    check("post_reset_latency", 32'(lat), 32'(WIDTH + 1));

    // Back-to-back random operations against the arithmetic model.
    wait_idle();
    for (int i = 0; i < 1000; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rc;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      issue(ra, rb, rc, model(ra, rb, rc), tries, lat);
      check("rand_latency", 32'(lat), 32'(WIDTH + 1));
      if (i > 0) check("rand_issue_gap", 32'(tries), 32'd2);
    end

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
